// File: rtl/mult32_seq.sv
// Sequential 32x32 signed multiplier: sign-magnitude shift-and-add over 32 cycles,
// then one cycle to restore the product sign and publish HI/LO.

// Two's-complement (negation) stage, shared by operand magnitude and result sign fix.
module mult32_tc #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  assign y = ~x + {{(W-1){1'b0}}, 1'b1};
endmodule

module mult32_seq (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        neg;
  logic [63:0] acc;
  logic [4:0]  cnt;

  logic [31:0] neg_a;
  logic [31:0] neg_b;
  logic [63:0] acc_neg;
  logic [32:0] sum;

  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  mult32_tc #(.W(32)) u_tc_a   (.x(A),   .y(neg_a));
  mult32_tc #(.W(32)) u_tc_b   (.x(B),   .y(neg_b));
  mult32_tc #(.W(64)) u_tc_acc (.x(acc), .y(acc_neg));

  // Carry out of the upper half is kept and shifted back into acc[63].
  assign sum = {1'b0, acc[63:32]} + (mag_b[0] ? {1'b0, mag_a} : 33'd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (START) state_nxt = S_RUN;
      S_RUN:   if (cnt == 5'd31) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mag_a  <= '0;
      mag_b  <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (START) begin
            mag_a <= A[31] ? neg_a : A;
            mag_b <= B[31] ? neg_b : B;
            neg   <= A[31] ^ B[31];
            acc   <= '0;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          acc   <= {sum, acc[31:1]};
          mag_b <= {acc[0], mag_b[31:1]};
          cnt   <= cnt + 5'd1;
        end
        S_FIX: begin
          {hi_q, lo_q} <= neg ? acc_neg : acc;
          done_q       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (state != S_IDLE);
  assign DONE = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
